// File: rtl/rl_sched_pkg.sv
// rl_sched_pkg: state encoding, home/half-shell cell coordinate table and
// lane-to-cell ownership shared by the pair scheduler and its lanes.
package rl_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_REF,
    S_LATCH_REF,
    S_EVAL,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int MAX_CELLS = 14;

  // Entry c is {x,y,z} of cell index c; index 0 sits in the LSBs.
  localparam logic [MAX_CELLS-1:0][11:0] CELL_XYZ = {
    12'h333, 12'h332, 12'h331, 12'h323, 12'h322, 12'h321, 12'h313,
    12'h312, 12'h311, 12'h233, 12'h232, 12'h231, 12'h223, 12'h222
  };

  function automatic logic [11:0] cell_xyz(input logic [3:0] c);
    return CELL_XYZ[c];
  endfunction

  function automatic int lane_of(input int c, input int nf);
    return c % nf;
  endfunction

endpackage

// File: rtl/rl_pair_lane.sv
// rl_pair_lane: walks the cells owned by one lane, issuing one neighbor
// address per free cycle and flagging when every owned cell is exhausted.
module rl_pair_lane
  import rl_sched_pkg::*;
#(
  parameter int LANE = 0,
  parameter int NF   = 4,
  parameter int NC   = 14,
  parameter int AW   = 8,
  parameter int CIW  = $clog2(NC)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           init_i,
  input  logic           run_i,
  input  logic           bp_i,
  input  logic [AW-1:0]  ref_addr_i,
  input  logic [NC*AW-1:0] cnt_i,
  output logic           issue_o,
  output logic           fin_o,
  output logic [CIW-1:0] cell_o,
  output logic [AW-1:0]  addr_o
);

  logic [CIW-1:0] cell_q, cell_d;
  logic [AW:0]    ptr_q, ptr_d;
  logic           fin_q, fin_d;
  logic [AW-1:0]  cnt;
  logic           more, last;

  assign cnt    = cnt_i[cell_q*AW +: AW];
  assign more   = ptr_q < {1'b0, cnt};
  assign last   = int'(cell_q) + NF >= NC;
  assign cell_o = cell_q;
  assign addr_o = ptr_q[AW-1:0];
  // Finishing is visible in the advance cycle itself so the FSM wastes no cycle.
  assign fin_o  = fin_q || (run_i && !more && last);

  always_comb begin
    cell_d  = cell_q;
    ptr_d   = ptr_q;
    fin_d   = fin_q;
    issue_o = run_i && !fin_q && more && !bp_i;
    if (init_i) begin
      cell_d = CIW'(LANE);
      ptr_d  = LANE == 0 ? {1'b0, ref_addr_i} + (AW+1)'(1) : '0;
      fin_d  = 1'b0;
    end else if (run_i && !fin_q) begin
      if (more) ptr_d = issue_o ? ptr_q + (AW+1)'(1) : ptr_q;
      else if (last) fin_d = 1'b1;
      else begin
        cell_d = cell_q + CIW'(NF);
        ptr_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cell_q <= '0;
      ptr_q  <= '0;
      fin_q  <= 1'b1;
    end else begin
      cell_q <= cell_d;
      ptr_q  <= ptr_d;
      fin_q  <= fin_d;
    end
  end

endmodule

// File: rtl/rl_pair_scheduler.sv
// rl_pair_scheduler: walks home-cell references against the half shell and
// issues reference/neighbor pairs on NUM_FILTER lanes into the force unit.
module rl_pair_scheduler
  import rl_sched_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int NUM_NEIGHBOR_CELLS = 13,
  parameter int CELL_ID_WIDTH      = 4,
  parameter int CELL_ADDR_WIDTH    = 8,
  parameter int PARTICLE_ID_WIDTH  = CELL_ID_WIDTH*3+CELL_ADDR_WIDTH,
  parameter int NUM_FILTER         = 4,
  parameter int DRAIN_CYCLES       = 31
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [(NUM_NEIGHBOR_CELLS+1)*CELL_ADDR_WIDTH-1:0] cell_particle_num,
  output logic cell_rden,
  output logic [(NUM_NEIGHBOR_CELLS+1)*CELL_ADDR_WIDTH-1:0] cell_read_addr,
  input  logic [(NUM_NEIGHBOR_CELLS+1)*3*DATA_WIDTH-1:0] cell_readout_position,
  input  logic [NUM_FILTER-1:0] backpressure,
  output logic [NUM_FILTER-1:0] pair_valid,
  output logic [NUM_FILTER*PARTICLE_ID_WIDTH-1:0] ref_particle_id,
  output logic [NUM_FILTER*PARTICLE_ID_WIDTH-1:0] neighbor_particle_id,
  output logic [NUM_FILTER*3*DATA_WIDTH-1:0] ref_particle_position,
  output logic [NUM_FILTER*3*DATA_WIDTH-1:0] neighbor_particle_position,
  output logic done
);

  localparam int NC  = NUM_NEIGHBOR_CELLS + 1;
  localparam int AW  = CELL_ADDR_WIDTH;
  localparam int CW  = CELL_ID_WIDTH;
  localparam int PW  = PARTICLE_ID_WIDTH;
  localparam int D3  = 3 * DATA_WIDTH;
  localparam int CIW = $clog2(NC);
  localparam int DCW = $clog2(DRAIN_CYCLES + 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   ref_addr_q, ref_addr_d;
  logic [D3-1:0]   ref_pos_q, ref_pos_d;
  logic [DCW-1:0]  drain_q, drain_d;
  logic [AW-1:0]   home_cnt;
  logic [NUM_FILTER-1:0] issue, fin, pv_q;
  logic [CIW-1:0]  lcell [NUM_FILTER];
  logic [AW-1:0]   laddr [NUM_FILTER];
  logic [CIW-1:0]  nb_cell_q [NUM_FILTER];
  logic [PW-1:0]   rid_q [NUM_FILTER];
  logic [PW-1:0]   nid_q [NUM_FILTER];
  logic [D3-1:0]   rpos_q [NUM_FILTER];

  function automatic logic [PW-1:0] pid(input logic [3:0] c, input logic [AW-1:0] a);
    logic [11:0] t;
    t = cell_xyz(c);
    return {CW'(t[11:8]), CW'(t[7:4]), CW'(t[3:0]), a};
  endfunction

  assign home_cnt  = cell_particle_num[AW-1:0];
  assign cell_rden = state_q == S_LOAD_REF || state_q == S_EVAL;
  assign done      = state_q == S_DONE;

  always_comb begin
    state_d    = state_q;
    ref_addr_d = ref_addr_q;
    ref_pos_d  = ref_pos_q;
    drain_d    = drain_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) begin
        state_d    = home_cnt == '0 ? S_DRAIN : S_LOAD_REF;
        ref_addr_d = '0;
        drain_d    = '0;
      end
      S_LOAD_REF: state_d = S_LATCH_REF;
      S_LATCH_REF: begin
        state_d   = S_EVAL;
        ref_pos_d = cell_readout_position[D3-1:0];
      end
      S_EVAL: if (&fin) begin
        if (ref_addr_q == home_cnt - AW'(1)) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          state_d    = S_LOAD_REF;
          ref_addr_d = ref_addr_q + AW'(1);
        end
      end
      S_DRAIN: begin
        state_d = drain_q == DCW'(DRAIN_CYCLES - 1) ? S_DONE : S_DRAIN;
        drain_d = drain_q + DCW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  for (genvar f = 0; f < NUM_FILTER; f++) begin : g_lane
    rl_pair_lane #(.LANE(f), .NF(NUM_FILTER), .NC(NC), .AW(AW), .CIW(CIW)) u_lane (
      .clk        (clk),
      .rst        (rst),
      .init_i     (state_q == S_LATCH_REF),
      .run_i      (state_q == S_EVAL),
      .bp_i       (backpressure[f]),
      .ref_addr_i (ref_addr_q),
      .cnt_i      (cell_particle_num),
      .issue_o    (issue[f]),
      .fin_o      (fin[f]),
      .cell_o     (lcell[f]),
      .addr_o     (laddr[f])
    );
    assign ref_particle_id[f*PW +: PW]      = rid_q[f];
    assign neighbor_particle_id[f*PW +: PW] = nid_q[f];
    assign ref_particle_position[f*D3 +: D3] = rpos_q[f];
    // Memory data arrives one cycle after the issue, matching the registered cell index.
    assign neighbor_particle_position[f*D3 +: D3] =
      pv_q[f] ? cell_readout_position[nb_cell_q[f]*D3 +: D3] : '0;
  end

  for (genvar c = 0; c < NC; c++) begin : g_addr
    localparam int L = lane_of(c, NUM_FILTER);
    assign cell_read_addr[c*AW +: AW] =
      (c == 0 && state_q == S_LOAD_REF) ? ref_addr_q :
      (issue[L] && lcell[L] == CIW'(c)) ? laddr[L] : '0;
  end

  assign pair_valid = pv_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ref_addr_q <= '0;
      ref_pos_q  <= '0;
      drain_q    <= '0;
      pv_q       <= '0;
      for (int f = 0; f < NUM_FILTER; f++) begin
        nb_cell_q[f] <= '0;
        rid_q[f]     <= '0;
        nid_q[f]     <= '0;
        rpos_q[f]    <= '0;
      end
    end else begin
      state_q    <= state_d;
      ref_addr_q <= ref_addr_d;
      ref_pos_q  <= ref_pos_d;
      drain_q    <= drain_d;
      pv_q       <= issue;
      for (int f = 0; f < NUM_FILTER; f++) begin
        nb_cell_q[f] <= lcell[f];
        rid_q[f]     <= pid(4'd0, ref_addr_q);
        nid_q[f]     <= pid(4'(lcell[f]), laddr[f]);
        rpos_q[f]    <= ref_pos_q;
      end
    end
  end

endmodule
